// File: rtl/accum_disp_pkg.sv
// Shared types and helpers for the AXI-Stream frame accumulator and its
// 7-segment output path.
package accum_disp_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Segment order is gfedcba, 1 = lit; anything that is not a decimal digit is dark.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] bcd_max(input int unsigned digits);
    logic [31:0] v;
    v = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: one bit per cycle, SUM_W cycles.
// ovf is set when any bit is shifted out of the top digit, i.e. bin > 10^D-1.
module bin2bcd_seq
  import accum_disp_pkg::*;
#(
  parameter int SUM_W = 6,
  parameter int D     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SUM_W-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic [D-1:0][3:0]    bcd,
  output logic                 ovf
);

  localparam int IT_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  r_bin;
  logic [D-1:0][3:0] r_bcd;
  logic [IT_W-1:0]   r_it;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic [4*D-1:0]    w_adj;

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < D; i++) begin
      if (r_bcd[i] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[i] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_bcd[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_it   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin  <= bin;
        r_bcd  <= '0;
        r_it   <= '0;
        r_busy <= 1'b1;
        r_ovf  <= 1'b0;
      end else if (r_busy) begin
        r_bin <= r_bin << 1;
        r_bcd <= {w_adj[4*D-2:0], r_bin[SUM_W-1]};
        r_ovf <= r_ovf | w_adj[4*D-1];
        r_it  <= r_it + IT_W'(1);
        if (r_it == IT_W'(SUM_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: rtl/axis_accum_bcd7seg.sv
// AXI-Stream frame accumulator: sums up to N samples per frame, converts the
// total to D decimal digits and presents them as 7-segment codes.
module axis_accum_bcd7seg
  import accum_disp_pkg::*;
#(
  parameter int W     = 3,
  parameter int N     = 5,
  parameter int D     = 2,
  parameter int BLANK = 0,
  localparam int SUM_W = $clog2(N * (2**W - 1) + 1),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [W-1:0]         s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [D-1:0][6:0]    m_data,
  output logic [CNT_W-1:0]     m_count,
  output logic                 m_ovf
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_s_ready;
  logic              r_m_valid;
  logic [D-1:0][6:0] r_m_data;
  logic [CNT_W-1:0]  r_m_count;
  logic              r_m_ovf;

  logic              w_acc;
  logic              w_close;
  logic              w_start;
  logic [SUM_W-1:0]  w_sum_nx;
  logic              w_busy;
  logic              w_done;
  logic [D-1:0][3:0] w_bcd;
  logic              w_ovf;
  logic [D-1:0][6:0] w_seg;

  assign w_acc    = s_valid & r_s_ready;
  assign w_close  = w_acc & ((r_cnt == CNT_W'(N - 1)) | s_last);
  assign w_start  = w_close & ~w_busy;
  assign w_sum_nx = r_sum + SUM_W'(s_data);

  bin2bcd_seq #(
    .SUM_W (SUM_W),
    .D     (D)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (w_sum_nx),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ACC:     if (w_close) w_state_nx = CONV; else w_state_nx = ACC;
      CONV:    if (w_done)  w_state_nx = OUT;  else w_state_nx = CONV;
      OUT:     if (m_ready) w_state_nx = ACC;  else w_state_nx = OUT;
      default: w_state_nx = ACC;
    endcase
  end

  // Saturation overrides blanking; blanking darkens zero digits above the ones place.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    w_seg = '0;
    for (int i = D - 1; i >= 0; i--) begin
      lead = lead & (w_bcd[i] == 4'd0);
      if (w_ovf) begin
        w_seg[i] = seg7_encode(4'd9);
      end else if ((BLANK != 0) && (i >= 1) && lead) begin
        w_seg[i] = SEG_OFF;
      end else begin
        w_seg[i] = seg7_encode(w_bcd[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_close) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_sum <= w_sum_nx;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_count <= '0;
      r_m_ovf   <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nx == ACC);
      if (w_close) begin
        r_m_count <= r_cnt + CNT_W'(1);
      end
      if ((r_state == CONV) && w_done) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_seg;
        r_m_ovf   <= w_ovf;
      end else if ((r_state == OUT) && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_count = r_m_count;
  assign m_ovf   = r_m_ovf;

endmodule

// File: tb/tb_axis_accum_bcd7seg.sv
// Directed scoreboard bench for axis_accum_bcd7seg over four parameter sets:
// defaults, BLANK=1, D=1 and N=1, selected one at a time through a shared stimulus port.
module tb_axis_accum_bcd7seg;

  localparam logic [6:0] S0  = 7'b0111111;
  localparam logic [6:0] S3  = 7'b1001111;
  localparam logic [6:0] S5  = 7'b1101101;
  localparam logic [6:0] S7  = 7'b0000111;
  localparam logic [6:0] S9  = 7'b1101111;
  localparam logic [6:0] OFF = 7'b0000000;

  typedef struct packed {
    logic [13:0] data;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       tb_s_valid;
  logic       tb_s_last;
  logic       tb_m_ready;
  logic [2:0] tb_s_data;
  int         sel;

  logic sv[4], mr[4], sr[4], mv[4], ov[4];
  logic [1:0][6:0] md0, md1, md3;
  logic [0:0][6:0] md2;
  logic [2:0] mc0, mc1, mc2;
  logic [0:0] mc3;

  logic [13:0] obs_data;
  logic [2:0]  obs_cnt;
  logic        obs_sready, obs_mvalid, obs_ovf;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sv[k] = tb_s_valid && (sel == k);
      mr[k] = tb_m_ready && (sel == k);
    end
  end

  always_comb begin
    case (sel)
      1:       begin obs_data = md1;             obs_cnt = mc1;           end
      2:       begin obs_data = {7'b0, md2};     obs_cnt = mc2;           end
      3:       begin obs_data = md3;             obs_cnt = {2'b0, mc3};   end
      default: begin obs_data = md0;             obs_cnt = mc0;           end
    endcase
    obs_sready = sr[sel];
    obs_mvalid = mv[sel];
    obs_ovf    = ov[sel];
  end

  axis_accum_bcd7seg #(.W(3), .N(5), .D(2), .BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(tb_s_data), .s_last(tb_s_last),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md0), .m_count(mc0), .m_ovf(ov[0]));
  axis_accum_bcd7seg #(.W(3), .N(5), .D(2), .BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(tb_s_data), .s_last(tb_s_last),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md1), .m_count(mc1), .m_ovf(ov[1]));
  axis_accum_bcd7seg #(.W(3), .N(5), .D(1), .BLANK(0)) dut2 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(tb_s_data), .s_last(tb_s_last),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md2), .m_count(mc2), .m_ovf(ov[2]));
  axis_accum_bcd7seg #(.W(3), .N(1), .D(2), .BLANK(0)) dut3 (
    .clk(clk), .rst(rst), .s_valid(sv[3]), .s_ready(sr[3]), .s_data(tb_s_data), .s_last(tb_s_last),
    .m_valid(mv[3]), .m_ready(mr[3]), .m_data(md3), .m_count(mc3), .m_ovf(ov[3]));

  int   tests = 0;
  int   fails = 0;
  int   acc_cyc = 0;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] d, input logic last);
    int t;
    t = 0;
    tb_s_valid = 1'b1;
    tb_s_data  = d;
    tb_s_last  = last;
    while (!obs_sready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!obs_sready) chk("send_ready_timeout", {31'b0, obs_sready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    tb_s_valid = 1'b0;
    tb_s_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int t;
    t = 0;
    while (!obs_mvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, {31'b0, obs_mvalid}, 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, cyc - acc_cyc, exp_lat);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, {18'b0, obs_data}, {18'b0, e.data});
      chk({tag, "_count"}, {29'b0, obs_cnt}, {29'b0, e.cnt});
      chk({tag, "_ovf"}, {31'b0, obs_ovf}, {31'b0, e.ovf});
    end
  endtask

  task automatic handshake(input string tag);
    tb_m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_m_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, obs_mvalid}, 32'd0);
    chk({tag, "_sready_next"}, {31'b0, obs_sready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    tb_s_valid = 1'b0;
    tb_s_last  = 1'b0;
    tb_m_ready = 1'b0;
    tb_s_data  = 3'd0;
    sel        = 0;
    repeat (3) @(negedge clk);
    chk("rst_sready", {31'b0, obs_sready}, 32'd0);
    chk("rst_mvalid", {31'b0, obs_mvalid}, 32'd0);
    chk("rst_mdata", {18'b0, obs_data}, 32'd0);
    chk("rst_mcount", {29'b0, obs_cnt}, 32'd0);
    chk("rst_movf", {31'b0, obs_ovf}, 32'd0);
    rst = 1'b0;

    // Full frame: 5 x 7 = 35, SUM_W = 6 so valid 7 edges after the last accept.
    q.push_back('{data: {S3, S5}, cnt: 3'd5, ovf: 1'b0});
    for (int i = 0; i < 5; i++) send(3'd7, 1'b0);
    wait_valid("full", 7);
    check_out("full");
    handshake("full");

    // Short frame 2+3 with and without leading-zero blanking.
    q.push_back('{data: {S0, S5}, cnt: 3'd2, ovf: 1'b0});
    send(3'd2, 1'b0);
    send(3'd3, 1'b1);
    wait_valid("short", 7);
    check_out("short");
    handshake("short");

    sel = 1;
    q.push_back('{data: {OFF, S5}, cnt: 3'd2, ovf: 1'b0});
    send(3'd2, 1'b0);
    send(3'd3, 1'b1);
    wait_valid("blank", 7);
    check_out("blank");
    handshake("blank");

    // D=1: 14 saturates to 9 with overflow flagged.
    sel = 2;
    q.push_back('{data: {7'b0, S9}, cnt: 3'd2, ovf: 1'b1});
    send(3'd7, 1'b0);
    send(3'd7, 1'b1);
    wait_valid("ovf", 7);
    check_out("ovf");
    handshake("ovf");

    // Backpressure: output held while a new sample waits upstream.
    sel = 0;
    q.push_back('{data: {S0, S3}, cnt: 3'd2, ovf: 1'b0});
    send(3'd1, 1'b0);
    send(3'd2, 1'b1);
    wait_valid("bp", 7);
    check_out("bp");
    tb_s_valid = 1'b1;
    tb_s_data  = 3'd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data", {18'b0, obs_data}, {18'b0, S0, S3});
      chk("bp_hold_valid", {31'b0, obs_mvalid}, 32'd1);
      chk("bp_hold_sready", {31'b0, obs_sready}, 32'd0);
    end
    handshake("bp");
    q.push_back('{data: {S0, S5}, cnt: 3'd2, ovf: 1'b0});
    send(3'd4, 1'b0);
    send(3'd1, 1'b1);
    wait_valid("bp_next", 7);
    check_out("bp_next");
    handshake("bp_next");

    // Reset in the 3rd CONV cycle discards the frame.
    send(3'd7, 1'b0);
    send(3'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mvalid", {31'b0, obs_mvalid}, 32'd0);
    chk("midrst_mdata", {18'b0, obs_data}, 32'd0);
    chk("midrst_mcount", {29'b0, obs_cnt}, 32'd0);
    chk("midrst_movf", {31'b0, obs_ovf}, 32'd0);
    chk("midrst_sready", {31'b0, obs_sready}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (obs_mvalid) seen++;
    end
    chk("midrst_no_valid", seen, 32'd0);
    q.push_back('{data: {S0, S5}, cnt: 3'd5, ovf: 1'b0});
    for (int i = 0; i < 5; i++) send(3'd1, 1'b0);
    wait_valid("after_rst", 7);
    check_out("after_rst");
    handshake("after_rst");

    // N=1: every beat is a frame; SUM_W = 3 so latency is 4.
    sel = 3;
    q.push_back('{data: {S0, S0}, cnt: 3'd1, ovf: 1'b0});
    q.push_back('{data: {S0, S7}, cnt: 3'd1, ovf: 1'b0});
    send(3'd0, 1'b0);
    wait_valid("n1_a", 4);
    check_out("n1_a");
    handshake("n1_a");
    send(3'd7, 1'b0);
    wait_valid("n1_b", 4);
    check_out("n1_b");
    handshake("n1_b");

    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
